// File: rtl/frac_lutk_cfg_if.sv
// Configuration port bundle for frac_lutk_cfg: word-wide valid/ready transfer
// channel plus load control and status. The cfg_parity wire exists only when
// FRAC_LUT_CFG_PARITY_EN is defined.
interface frac_lutk_cfg_if #(
   parameter int WORD = 8
);
   logic            cfg_start;
   logic            cfg_valid;
   logic            cfg_ready;
   logic [WORD-1:0] cfg_data;
   logic            cfg_last;
   logic            cfg_done;
   logic            cfg_err;
`ifdef FRAC_LUT_CFG_PARITY_EN
   logic            cfg_parity;

   modport master (
      output cfg_start, cfg_valid, cfg_data, cfg_last, cfg_parity,
      input  cfg_ready, cfg_done, cfg_err
   );
   modport slave (
      input  cfg_start, cfg_valid, cfg_data, cfg_last, cfg_parity,
      output cfg_ready, cfg_done, cfg_err
   );
`else
   modport master (
      output cfg_start, cfg_valid, cfg_data, cfg_last,
      input  cfg_ready, cfg_done, cfg_err
   );
   modport slave (
      input  cfg_start, cfg_valid, cfg_data, cfg_last,
      output cfg_ready, cfg_done, cfg_err
   );
`endif
endinterface

// File: rtl/frac_lutk_cfg.sv
// Fracturable K-input LUT with its own truth-table SRAM, loaded word by word
// through a small loader FSM (IDLE/LOAD/DONE/ERR). Drives one K-input, two
// (K-1)-input and four (K-2)-input outputs; all of them read 0 until a load
// has completed cleanly, so a partial truth table never reaches the fabric.
// Optional feature macro: FRAC_LUT_CFG_PARITY_EN adds an even-parity check
// on every configuration word.
// Legal parameters: K in 4..8, WORD a divisor of 2**K.
module frac_lutk_cfg #(
   parameter int K    = 6,
   parameter int WORD = 8
) (
   input  logic                prog_clk,
   input  logic                pReset,
   frac_lutk_cfg_if.slave      cfg,
   input  logic [K-1:0]        in,
   input  logic [1:0]          mode,
   output logic [3:0]          lutk2_out,
   output logic [1:0]          lutk1_out,
   output logic                lutk_out
);
   localparam int NUM_BITS  = 2 ** K;
   localparam int NUM_WORDS = NUM_BITS / WORD;
   localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

   state_t              state;
   logic [CNT_W-1:0]    word_cnt;
   logic [NUM_BITS-1:0] sram;
   logic                ready_q;
   logic                done_q;
   logic                err_q;
   logic                par_err;
   logic [K-1:0]        sel;

   assign cfg.cfg_ready = ready_q;
   assign cfg.cfg_done  = done_q;
   assign cfg.cfg_err   = err_q;

`ifdef FRAC_LUT_CFG_PARITY_EN
   // Even parity over data plus parity bit; a set result flags a corrupt word.
   assign par_err = ^{cfg.cfg_data, cfg.cfg_parity};
`else
   assign par_err = 1'b0;
`endif

   // Loader FSM: start has top priority, then parity, then framing on cfg_last.
   // Status outputs are registered alongside the state they describe.
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state    <= IDLE;
         word_cnt <= '0;
         // NOTE: the truth-table SRAM is reset too, so a tile never powers up
         // holding random logic; the output gating alone would hide it, but a
         // cleared array keeps restarts and debug deterministic.
         sram     <= '0;
         ready_q  <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else if (cfg.cfg_start) begin
         // NOTE: non-blocking assignments keep every register update here
         // order-independent; blocking would make later lines see new values.
         state    <= LOAD;
         word_cnt <= '0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else if (state == LOAD && cfg.cfg_valid) begin
         if (par_err) begin
            // Corrupt word: leave SRAM and count untouched.
            state   <= ERR;
            ready_q <= 1'b0;
            err_q   <= 1'b1;
         end else begin
            sram[int'(word_cnt) * WORD +: WORD] <= cfg.cfg_data;
            if (word_cnt == LAST_CNT) begin
               // Final slot: the load must end here, cleanly or not.
               ready_q <= 1'b0;
               if (cfg.cfg_last) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end else begin
                  state  <= ERR;
                  err_q  <= 1'b1;
               end
            end else if (cfg.cfg_last) begin
               // Early end of frame: the word is kept, the load is not.
               state    <= ERR;
               ready_q  <= 1'b0;
               err_q    <= 1'b1;
               word_cnt <= word_cnt + 1'b1;
            end else begin
               word_cnt <= word_cnt + 1'b1;
            end
         end
      end
   end

   // Effective select: the fracture mode bits force the two top selects high.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      sel      = in;
      sel[K-2] = in[K-2] | mode[0];
      sel[K-1] = in[K-1] | mode[1];
   end

   // Truth-table read, gated so only a completely loaded table is visible.
   always_comb begin
      lutk_out  = 1'b0;
      lutk1_out = '0;
      lutk2_out = '0;
      if (state == DONE) begin
         lutk_out = sram[sel];
         for (int i = 0; i < 2; i++)
            lutk1_out[i] = sram[i * (2 ** (K-1)) + int'(sel[K-2:0])];
         for (int i = 0; i < 4; i++)
            lutk2_out[i] = sram[i * (2 ** (K-2)) + int'(sel[K-3:0])];
      end
   end
endmodule

// File: tb/tb_frac_lutk_cfg.sv
// Self-checking bench for frac_lutk_cfg (K=6, WORD=8): directed vector table
// for the known truth tables, hand-written framing/restart sequences, and
// randomized loads checked against a bit-array reference model.
module tb_frac_lutk_cfg;
   localparam int K = 6;
   localparam int WORD = 8;
   localparam int NUM_WORDS = 8;

   typedef struct {
      int         pat;      // 0: all words 8'hAA, 1: word0 8'hFF, rest 0
      logic [5:0] in;
      logic [1:0] mode;
      logic       exp_k;
      logic [1:0] exp_k1;
      logic [3:0] exp_k2;
   } vec_t;

   logic       prog_clk = 1'b0;
   logic       pReset;
   logic [5:0] lut_in;
   logic [1:0] lut_mode;
   logic [3:0] lutk2_out;
   logic [1:0] lutk1_out;
   logic       lutk_out;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: truth table as a plain bit array plus a "loaded" flag.
   bit model_mem[64];
   bit model_done;

   frac_lutk_cfg_if #(.WORD(WORD)) cfg_bus ();

   frac_lutk_cfg #(.K(K), .WORD(WORD)) dut (
      .prog_clk  (prog_clk),
      .pReset    (pReset),
      .cfg       (cfg_bus),
      .in        (lut_in),
      .mode      (lut_mode),
      .lutk2_out (lutk2_out),
      .lutk1_out (lutk1_out),
      .lutk_out  (lutk_out)
   );

   always #5 prog_clk = ~prog_clk;

   initial begin
      #2ms;
      $display("FAIL global_timeout act=running req=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int unsigned act, input int unsigned req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s act=%0h req=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   // Expected {k2, k1, k} from the model with plain index arithmetic.
   function automatic logic [6:0] model_out(input int a, input int m);
      int idx = a | (m << 4);
      logic [6:0] r = '0;
      if (!model_done) return r;
      r[0] = model_mem[idx];
      for (int i = 0; i < 2; i++) r[1 + i] = model_mem[i * 32 + idx % 32];
      for (int i = 0; i < 4; i++) r[3 + i] = model_mem[i * 16 + idx % 16];
      return r;
   endfunction

   task automatic check_lut(input string name, input logic [5:0] a, input logic [1:0] m);
      logic [6:0] e;
      lut_in = a;
      lut_mode = m;
      #1;
      e = model_out(int'(a), int'(m));
      check({name, "_k"},  lutk_out,  e[0]);
      check({name, "_k1"}, lutk1_out, e[2:1]);
      check({name, "_k2"}, lutk2_out, e[6:3]);
   endtask

   task automatic model_word(input int n, input logic [7:0] d);
      for (int b = 0; b < WORD; b++) model_mem[n * WORD + b] = d[b];
   endtask

   task automatic start_load();
      cfg_bus.cfg_start = 1'b1;
      tick();
      cfg_bus.cfg_start = 1'b0;
      model_done = 1'b0;
   endtask

   // One transfer with a bounded wait for cfg_ready.
   task automatic send_word(input logic [7:0] d, input bit last, input bit bad_par);
      int waited = 0;
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_data  = d;
      cfg_bus.cfg_last  = last;
`ifdef FRAC_LUT_CFG_PARITY_EN
      cfg_bus.cfg_parity = (^d) ^ bad_par;
`endif
      while (!cfg_bus.cfg_ready && waited < 20) begin
         tick();
         waited++;
      end
      if (!cfg_bus.cfg_ready) check("ready_timeout", 0, 1);
      tick();
      cfg_bus.cfg_valid = 1'b0;
      cfg_bus.cfg_last  = 1'b0;
   endtask

   // Full clean load of 8 words, model updated alongside.
   task automatic load_all(input logic [7:0] w[NUM_WORDS]);
      for (int n = 0; n < NUM_WORDS; n++) begin
         send_word(w[n], n == NUM_WORDS - 1, 1'b0);
         model_word(n, w[n]);
      end
      model_done = 1'b1;
   endtask

   task automatic sweep(input string name);
      for (int a = 0; a < 64; a++) check_lut(name, 6'(a), 2'b00);
   endtask

   vec_t vecs[9];
   logic [7:0] words[NUM_WORDS];

   initial begin
      vecs[0] = '{0, 6'h01, 2'b00, 1'b1, 2'b11, 4'hF};
      vecs[1] = '{0, 6'h00, 2'b00, 1'b0, 2'b00, 4'h0};
      vecs[2] = '{1, 6'h05, 2'b00, 1'b1, 2'b01, 4'b0001};
      vecs[3] = '{1, 6'h05, 2'b11, 1'b0, 2'b00, 4'b0001};
      vecs[4] = '{1, 6'h08, 2'b00, 1'b0, 2'b00, 4'b0000};
      vecs[5] = '{1, 6'h07, 2'b00, 1'b1, 2'b01, 4'b0001};
      vecs[6] = '{1, 6'h10, 2'b00, 1'b0, 2'b00, 4'b0001};
      vecs[7] = '{1, 6'h00, 2'b10, 1'b0, 2'b01, 4'b0001};
      vecs[8] = '{1, 6'h3F, 2'b00, 1'b0, 2'b00, 4'b0000};

      cfg_bus.cfg_start = 1'b0;
      cfg_bus.cfg_valid = 1'b0;
      cfg_bus.cfg_data  = '0;
      cfg_bus.cfg_last  = 1'b0;
`ifdef FRAC_LUT_CFG_PARITY_EN
      cfg_bus.cfg_parity = 1'b0;
`endif
      lut_mode = 2'b00;
      lut_in   = 6'h3F;
      model_done = 1'b0;
      foreach (model_mem[i]) model_mem[i] = 1'b0;

      // Reset state, checked while reset is held.
      pReset = 1'b1;
      tick();
      tick();
      check("rst_ready", cfg_bus.cfg_ready, 0);
      check("rst_done",  cfg_bus.cfg_done,  0);
      check("rst_err",   cfg_bus.cfg_err,   0);
      check("rst_k",     lutk_out,  0);
      check("rst_k1",    lutk1_out, 0);
      check("rst_k2",    lutk2_out, 0);
      pReset = 1'b0;
      tick();

      // Directed truth tables driven from the vector table.
      for (int p = 0; p < 2; p++) begin
         start_load();
         check("load_ready", cfg_bus.cfg_ready, 1);
         for (int n = 0; n < NUM_WORDS; n++) begin
            words[n] = (p == 0) ? 8'hAA : ((n == 0) ? 8'hFF : 8'h00);
            send_word(words[n], n == NUM_WORDS - 1, 1'b0);
            model_word(n, words[n]);
            if (n == NUM_WORDS - 2) check("done_early", cfg_bus.cfg_done, 0);
         end
         model_done = 1'b1;
         check("done_after_last", cfg_bus.cfg_done, 1);
         check("ready_after_done", cfg_bus.cfg_ready, 0);
         for (int i = 0; i < 9; i++) begin
            if (vecs[i].pat == p) begin
               lut_in = vecs[i].in;
               lut_mode = vecs[i].mode;
               #1;
               check($sformatf("vec%0d_k", i),  lutk_out,  vecs[i].exp_k);
               check($sformatf("vec%0d_k1", i), lutk1_out, vecs[i].exp_k1);
               check($sformatf("vec%0d_k2", i), lutk2_out, vecs[i].exp_k2);
            end
         end
      end

      // Early cfg_last on word 3 aborts; a fresh load then recovers.
      start_load();
      for (int n = 0; n < 4; n++) begin
         send_word(8'h30 + 8'(n), n == 3, 1'b0);
         model_word(n, 8'h30 + 8'(n));
      end
      check("early_last_err",   cfg_bus.cfg_err,   1);
      check("early_last_ready", cfg_bus.cfg_ready, 0);
      check("early_last_done",  cfg_bus.cfg_done,  0);
      check_lut("err_gate", 6'h05, 2'b00);
      tick();
      check("err_holds", cfg_bus.cfg_err, 1);
      start_load();
      check("restart_err_clear", cfg_bus.cfg_err, 0);
      for (int n = 0; n < NUM_WORDS; n++) words[n] = 8'($urandom);
      load_all(words);
      check("recover_err",  cfg_bus.cfg_err,  0);
      check("recover_done", cfg_bus.cfg_done, 1);
      sweep("recover");

      // Missing cfg_last on the final word is a framing error.
      start_load();
      for (int n = 0; n < NUM_WORDS; n++) begin
         send_word(8'h0F, 1'b0, 1'b0);
         model_word(n, 8'h0F);
      end
      check("no_last_err",  cfg_bus.cfg_err,  1);
      check("no_last_done", cfg_bus.cfg_done, 0);

      // Restart mid-load: start beats the simultaneous word 4, count restarts.
      start_load();
      for (int n = 0; n < 4; n++) send_word(8'h11 * 8'(n), 1'b0, 1'b0);
      cfg_bus.cfg_start = 1'b1;
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_data  = 8'h5A;
      tick();
      cfg_bus.cfg_start = 1'b0;
      cfg_bus.cfg_valid = 1'b0;
      check("restart_ready", cfg_bus.cfg_ready, 1);
      check("restart_done",  cfg_bus.cfg_done,  0);
      for (int n = 0; n < NUM_WORDS - 1; n++) begin
         words[n] = 8'($urandom);
         send_word(words[n], 1'b0, 1'b0);
         model_word(n, words[n]);
      end
      check("restart_not_done", cfg_bus.cfg_done, 0);
      check("restart_no_err",   cfg_bus.cfg_err,  0);
      words[7] = 8'hC3;
      send_word(words[7], 1'b1, 1'b0);
      model_word(7, words[7]);
      model_done = 1'b1;
      check("restart_final_done", cfg_bus.cfg_done, 1);
      sweep("restart");

`ifdef FRAC_LUT_CFG_PARITY_EN
      // Odd parity on word 2 aborts the load without writing it.
      start_load();
      for (int n = 0; n < 3; n++) send_word(8'h01, 1'b0, n == 2);
      check("parity_err",   cfg_bus.cfg_err,   1);
      check("parity_ready", cfg_bus.cfg_ready, 0);
      check("parity_done",  cfg_bus.cfg_done,  0);
`else
      // Without the parity check, odd-parity data loads normally.
      start_load();
      for (int n = 0; n < NUM_WORDS; n++) words[n] = (n == 2) ? 8'h01 : 8'h80;
      load_all(words);
      check("noparity_done", cfg_bus.cfg_done, 1);
      check("noparity_err",  cfg_bus.cfg_err,  0);
      sweep("noparity");
`endif

      // Randomized loads with random framing against the reference model.
      for (int it = 0; it < 12; it++) begin
         int r = $urandom_range(0, 9);
         int p = (r >= 6 && r < 8) ? $urandom_range(0, 6) : NUM_WORDS - 1;
         start_load();
         for (int n = 0; n <= p; n++) begin
            logic [7:0] d = 8'($urandom);
            send_word(d, (n == p) && (r < 8), 1'b0);
            model_word(n, d);
         end
         model_done = (r < 6);
         check($sformatf("rnd%0d_done", it), cfg_bus.cfg_done, model_done);
         check($sformatf("rnd%0d_err", it),  cfg_bus.cfg_err,  !model_done);
         for (int j = 0; j < 6; j++)
            check_lut($sformatf("rnd%0d_%0d", it, j), 6'($urandom), 2'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
